// File: rtl/dot_acc_int_if.sv
// dot_acc_int_if: beat-input and result-output handshake bundle for dot_acc_int.
//   Input side : i_valid, o_ready, i_dp (signed), i_scale, i_last
//   Output side: o_valid, i_ready, o_dp (signed), o_scale, o_count, o_ovf
//   slave modport  -> the accumulator block
//   master modport -> the upstream/downstream environment
interface dot_acc_int_if #(
  parameter int in_width  = 8,
  parameter int acc_width = 24,
  parameter int max_beats = 64
);
  localparam int cw = $clog2(max_beats + 1);

  logic                        i_valid;
  logic                        o_ready;
  logic signed [in_width-1:0]  i_dp;
  logic [7:0]                  i_scale;
  logic                        i_last;
  logic                        o_valid;
  logic                        i_ready;
  logic signed [acc_width-1:0] o_dp;
  logic [7:0]                  o_scale;
  logic [cw-1:0]               o_count;
  logic                        o_ovf;

  modport slave (
    input  i_valid, i_dp, i_scale, i_last, i_ready,
    output o_ready, o_valid, o_dp, o_scale, o_count, o_ovf
  );

  modport master (
    output i_valid, i_dp, i_scale, i_last, i_ready,
    input  o_ready, o_valid, o_dp, o_scale, o_count, o_ovf
  );
endinterface

// File: rtl/dot_acc_int.sv
// dot_acc_int: folds a stream of (partial dot product, 8-bit scale) beats into
// one scaled, saturating integer result per row. Scales are aligned by letting
// the larger scale win and arithmetic-right-shifting the other operand.
// Ports:
//   i_clk  clock
//   i_rst  synchronous active-high reset
//   bus    dot_acc_int_if.slave: beat input (i_valid/o_ready/i_dp/i_scale/i_last)
//          and result output (o_valid/i_ready/o_dp/o_scale/o_count/o_ovf)
module dot_acc_int #(
  parameter int in_width  = 8,
  parameter int acc_width = 24,
  parameter int max_beats = 64
) (
  input  logic           i_clk,
  input  logic           i_rst,
  dot_acc_int_if.slave   bus
);
  localparam int cw = $clog2(max_beats + 1);

  typedef enum logic {ACC, OUT} state_t;
  state_t state;

  logic signed [acc_width-1:0] acc, x, op_a, op_b, acc_sat;
  logic signed [acc_width:0]   sum;
  logic [7:0]                  acc_scale, d;
  logic [cw-1:0]               count, count_nxt;
  logic                        ovf, ovf_nxt, first, sat;
  logic                        valid_r, ready_r, accept;

  // Shifts of acc_width or more collapse to the sign fill (0 or -1).
  function automatic logic signed [acc_width-1:0] asr(
    input logic signed [acc_width-1:0] v,
    input logic [7:0]                  sh
  );
    if (int'(sh) >= acc_width) return v[acc_width-1] ? '1 : '0;
    else return v >>> sh;
  endfunction

  assign accept = bus.i_valid & ready_r;

  always_comb begin
    x    = acc_width'(bus.i_dp);
    op_a = acc;
    op_b = x;
    d    = '0;
    if (bus.i_scale > acc_scale) begin
      d    = bus.i_scale - acc_scale;
      op_a = asr(acc, d);
    end else if (bus.i_scale < acc_scale) begin
      d    = acc_scale - bus.i_scale;
      op_b = asr(x, d);
    end
    // One guard bit: overflow shows as the top two sum bits disagreeing.
    sum = (acc_width+1)'(op_a) + (acc_width+1)'(op_b);
    sat = sum[acc_width] != sum[acc_width-1];
    if (!sat)
      acc_sat = sum[acc_width-1:0];
    else if (sum[acc_width])
      acc_sat = {1'b1, {(acc_width-1){1'b0}}};
    else
      acc_sat = {1'b0, {(acc_width-1){1'b1}}};

    if (count == cw'(max_beats)) begin
      count_nxt = count;
      ovf_nxt   = 1'b1;
    end else begin
      count_nxt = count + cw'(1);
      ovf_nxt   = ovf;
    end
    ovf_nxt = ovf_nxt | sat;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ACC;
      first     <= 1'b1;
      valid_r   <= 1'b0;
      ready_r   <= 1'b1;
      acc       <= '0;
      acc_scale <= '0;
      count     <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (first) begin
              acc       <= x;
              acc_scale <= bus.i_scale;
              count     <= cw'(1);
              ovf       <= 1'b0;
              first     <= 1'b0;
            end else begin
              acc       <= acc_sat;
              if (bus.i_scale > acc_scale) acc_scale <= bus.i_scale;
              count     <= count_nxt;
              ovf       <= ovf_nxt;
            end
            if (bus.i_last) begin
              state   <= OUT;
              valid_r <= 1'b1;
              ready_r <= 1'b0;
            end
          end
        end
        OUT: begin
          if (bus.i_ready) begin
            state   <= ACC;
            first   <= 1'b1;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign bus.o_dp    = acc;
  assign bus.o_scale = acc_scale;
  assign bus.o_count = count;
  assign bus.o_ovf   = ovf;
  assign bus.o_valid = valid_r;
  assign bus.o_ready = ready_r;
endmodule

// File: tb/tb_dot_acc_int.sv
// tb_dot_acc_int: drives two dot_acc_int instances (acc_width 24 / max_beats 64
// and acc_width 10 / max_beats 6) with identical beats and checks both against
// constant tables, hand sequences and a plain-arithmetic reference model.
module tb_dot_acc_int;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              valid = 1'b0;
  logic signed [7:0] dp    = '0;
  logic [7:0]        sc    = '0;
  logic              last  = 1'b0;
  logic              rdy   = 1'b0;

  dot_acc_int_if #(.in_width(8), .acc_width(24), .max_beats(64)) b24 ();
  dot_acc_int_if #(.in_width(8), .acc_width(10), .max_beats(6))  b10 ();

  assign b24.i_valid = valid;  assign b10.i_valid = valid;
  assign b24.i_dp    = dp;     assign b10.i_dp    = dp;
  assign b24.i_scale = sc;     assign b10.i_scale = sc;
  assign b24.i_last  = last;   assign b10.i_last  = last;
  assign b24.i_ready = rdy;    assign b10.i_ready = rdy;

  dot_acc_int #(.in_width(8), .acc_width(24), .max_beats(64)) u24 (
    .i_clk(clk), .i_rst(rst), .bus(b24.slave));
  dot_acc_int #(.in_width(8), .acc_width(10), .max_beats(6)) u10 (
    .i_clk(clk), .i_rst(rst), .bus(b10.slave));

  int checks = 0;
  int errors = 0;

  // Reference model, index 0 = 24-bit instance, 1 = 10-bit instance.
  longint m_acc[2];
  int     m_scale[2];
  int     m_n[2];
  bit     m_ovf[2];
  bit     m_first[2];
  int     m_w[2]  = '{24, 10};
  int     m_mb[2] = '{64, 6};

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // floor(v / 2^d)
  function automatic longint fdiv(input longint v, input int d);
    longint p;
    if (d >= 62) return (v < 0) ? -1 : 0;
    p = longint'(1) << d;
    if (v >= 0) return v / p;
    return -((-v + p - 1) / p);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_scale[k] = 0; m_n[k] = 0; m_ovf[k] = 0; m_first[k] = 1;
    end
  endtask

  task automatic m_fold(input int v, input int s);
    longint hi, lo;
    for (int k = 0; k < 2; k++) begin
      if (m_first[k]) begin
        m_acc[k] = v; m_scale[k] = s; m_n[k] = 1; m_ovf[k] = 0; m_first[k] = 0;
      end else begin
        if (s > m_scale[k]) begin
          m_acc[k] = fdiv(m_acc[k], s - m_scale[k]) + v;
          m_scale[k] = s;
        end else begin
          m_acc[k] = m_acc[k] + fdiv(v, m_scale[k] - s);
        end
        hi = (longint'(1) << (m_w[k] - 1)) - 1;
        lo = -(longint'(1) << (m_w[k] - 1));
        if (m_acc[k] > hi) begin m_acc[k] = hi; m_ovf[k] = 1; end
        if (m_acc[k] < lo) begin m_acc[k] = lo; m_ovf[k] = 1; end
        m_n[k]++;
        if (m_n[k] > m_mb[k]) m_ovf[k] = 1;
      end
    end
  endtask

  function automatic int m_cnt(input int k);
    return (m_n[k] > m_mb[k]) ? m_mb[k] : m_n[k];
  endfunction

  task automatic send(input int v, input int s, input bit l);
    int waited = 0;
    @(negedge clk);
    while (!b24.o_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!b24.o_ready) begin
      chk("ready_timeout", b24.o_ready, 1);
      return;
    end
    dp = 8'(v); sc = 8'(s); last = l; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0; last = 1'b0;
    m_fold(v, s);
  endtask

  task automatic check_out(input string tag, input bit exp_valid);
    chk({tag, " valid24"}, b24.o_valid, exp_valid);
    chk({tag, " valid10"}, b10.o_valid, exp_valid);
    chk({tag, " ready24"}, b24.o_ready, !exp_valid);
    chk({tag, " dp24"},    b24.o_dp,    m_acc[0]);
    chk({tag, " dp10"},    b10.o_dp,    m_acc[1]);
    chk({tag, " scale24"}, b24.o_scale, m_scale[0]);
    chk({tag, " scale10"}, b10.o_scale, m_scale[1]);
    chk({tag, " cnt24"},   b24.o_count, m_cnt(0));
    chk({tag, " cnt10"},   b10.o_count, m_cnt(1));
    chk({tag, " ovf24"},   b24.o_ovf,   m_ovf[0]);
    chk({tag, " ovf10"},   b10.o_ovf,   m_ovf[1]);
  endtask

  // Called right after the last beat's accepting edge: result due next cycle.
  task automatic expect_result(input string tag);
    @(negedge clk);
    check_out(tag, 1'b1);
  endtask

  task automatic release_out(input string tag);
    rdy = 1'b1;
    @(posedge clk);
    #1 rdy = 1'b0;
    for (int k = 0; k < 2; k++) m_first[k] = 1;
    @(negedge clk);
    chk({tag, " rel_valid"}, b24.o_valid, 0);
    chk({tag, " rel_ready"}, b24.o_ready, 1);
  endtask

  typedef struct {
    int dp; int sc; bit last; int e_dp; int e_sc; int e_cnt; bit e_ovf;
  } vec_t;
  vec_t tbl[14];

  initial begin
    longint held;
    tbl[0]  = '{10, 5, 0, 0, 0, 0, 0};
    tbl[1]  = '{20, 5, 0, 0, 0, 0, 0};
    tbl[2]  = '{-4, 5, 1, 26, 5, 3, 0};
    tbl[3]  = '{64, 3, 0, 0, 0, 0, 0};
    tbl[4]  = '{8, 5, 1, 24, 5, 2, 0};
    tbl[5]  = '{16, 4, 0, 0, 0, 0, 0};
    tbl[6]  = '{-7, 2, 1, 14, 4, 2, 0};
    tbl[7]  = '{5, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{-3, 200, 1, -3, 200, 2, 0};
    tbl[9]  = '{-128, 7, 1, -128, 7, 1, 0};
    tbl[10] = '{-50, 10, 0, 0, 0, 0, 0};
    tbl[11] = '{3, 0, 1, -50, 10, 2, 0};
    tbl[12] = '{-1, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 100, 1, -1, 100, 2, 0};

    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_out("reset", 1'b0);

    // Table of spec rows on the 24-bit instance
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].dp, tbl[i].sc, tbl[i].last);
      if (tbl[i].last) begin
        expect_result($sformatf("tbl%0d", i));
        chk($sformatf("tbl%0d c_dp", i),  b24.o_dp,    tbl[i].e_dp);
        chk($sformatf("tbl%0d c_sc", i),  b24.o_scale, tbl[i].e_sc);
        chk($sformatf("tbl%0d c_cnt", i), b24.o_count, tbl[i].e_cnt);
        chk($sformatf("tbl%0d c_ovf", i), b24.o_ovf,   tbl[i].e_ovf);
        release_out($sformatf("tbl%0d", i));
      end
    end

    // Saturation on the 10-bit instance, then a clean row
    for (int i = 0; i < 5; i++) send(127, 0, i == 4);
    expect_result("sat");
    chk("sat c_dp10", b10.o_dp, 511);
    chk("sat c_ovf10", b10.o_ovf, 1);
    chk("sat c_dp24", b24.o_dp, 635);
    chk("sat c_ovf24", b24.o_ovf, 0);
    release_out("sat");
    send(1, 0, 1);
    expect_result("sat_next");
    chk("sat_next c_dp10", b10.o_dp, 1);
    chk("sat_next c_ovf10", b10.o_ovf, 0);
    release_out("sat_next");

    // Beat-count limit: 6 beats fits max_beats=6, 7 beats overflows
    for (int i = 0; i < 6; i++) send(0, 0, i == 5);
    expect_result("cnt6");
    chk("cnt6 c_cnt10", b10.o_count, 6);
    chk("cnt6 c_ovf10", b10.o_ovf, 0);
    release_out("cnt6");
    for (int i = 0; i < 7; i++) send(0, 0, i == 6);
    expect_result("cnt7");
    chk("cnt7 c_cnt10", b10.o_count, 6);
    chk("cnt7 c_ovf10", b10.o_ovf, 1);
    chk("cnt7 c_cnt24", b24.o_count, 7);
    release_out("cnt7");

    // Backpressure: result held for 5 cycles, then a second row
    send(10, 5, 0); send(20, 5, 0); send(-4, 5, 1);
    expect_result("bp");
    held = b24.o_dp;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_out($sformatf("bp_hold%0d", i), 1'b1);
      chk($sformatf("bp_hold%0d c_dp", i), b24.o_dp, 26);
    end
    release_out("bp");
    send(1, 1, 0); send(2, 1, 1);
    expect_result("bp_row2");
    chk("bp_row2 c_dp", b24.o_dp, 3);
    chk("bp_row2 c_cnt", b24.o_count, 2);
    release_out("bp_row2");

    // Reset mid-row discards the partial row
    send(100, 1, 0); send(50, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    @(negedge clk);
    check_out("midrst", 1'b0);
    send(7, 2, 1);
    expect_result("midrst_row");
    chk("midrst_row c_dp", b24.o_dp, 7);
    chk("midrst_row c_sc", b24.o_scale, 2);
    chk("midrst_row c_cnt", b24.o_count, 1);
    release_out("midrst_row");

    // Random rows against the model
    for (int r = 0; r < 40; r++) begin
      int nb;
      nb = $urandom_range(1, 9);
      for (int b = 0; b < nb; b++) begin
        int v, s;
        v = int'($urandom_range(0, 255)) - 128;
        s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 6));
        send(v, s, b == nb - 1);
      end
      expect_result($sformatf("rnd%0d", r));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check_out($sformatf("rnd%0d_hold", r), 1'b1);
      end
      release_out($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dot_acc_int.md
Name: dot_acc_int

Overview:
- Streaming accumulator directly downstream of the integer general dot-product stage.
- Consumes a sequence of (partial dot product, shared 8-bit scale) beats, one per reduction chunk of a long row, and folds them into one scaled integer result.
- Aligns scales using the same "larger scale wins, smaller operand arithmetic-right-shifted" rule as the in-tree normalising adder.
- Emits one (dp, scale) result per row to the next stage over a valid/ready handshake.

Parameters:
- in_width, 8, width of signed input partial dot product; must satisfy in_width <= acc_width.
- acc_width, 24, width of signed accumulator and of o_dp.
- max_beats, 64, maximum beats per row; sizes o_count.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  input beat valid.
- o_ready  output  1  block can accept an input beat.
- i_dp  input  in_width  signed partial dot product.
- i_scale  input  8  unsigned shared scale of i_dp.
- i_last  input  1  final beat of the current row.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_dp  output  acc_width  signed accumulated result.
- o_scale  output  8  unsigned scale of o_dp.
- o_count  output  $clog2(max_beats+1)  beats folded into this result, saturating at max_beats.
- o_ovf  output  1  sticky per row: saturation occurred or beat count exceeded max_beats.

Behaviour:
- Clock and reset:
  - Single clock i_clk.
  - i_rst is synchronous and active-high; it dominates all other inputs.
- Reset state:
  - FSM = ACC, first = 1.
  - o_valid = 0, o_ready = 1 (registered).
  - o_dp = 0, o_scale = 0, o_count = 0, o_ovf = 0.
  - Reset mid-row or while OUT discards the partial row or held result. Nothing is emitted.
- Input handshake: a beat is accepted on any rising edge with i_valid & o_ready.
- FSM:
  - ACC: o_ready = 1, o_valid = 0. Accepts beats.
    - Accepted beat with i_last = 0: fold it; stay in ACC.
    - Accepted beat with i_last = 1: fold it; go to OUT at the same edge.
  - OUT: o_ready = 0, o_valid = 1.
    - o_dp, o_scale, o_count and o_ovf are held stable while o_valid & !i_ready.
    - On i_ready: go to ACC and set first = 1. The next beat can be accepted one cycle after the handshake.
- Latency: o_valid rises in the cycle after the edge that accepted the i_last beat.
- Fold, first beat of a row (first = 1):
  - acc = sign-extend(i_dp) to acc_width; acc_scale = i_scale.
  - count = 1, ovf = 0, first = 0.
- Fold, subsequent beats: let x = sign-extend(i_dp), d = |i_scale - acc_scale|.
  - If i_scale > acc_scale: acc := (acc >>> d) + x; acc_scale := i_scale.
  - If i_scale < acc_scale: acc := acc + (x >>> d); acc_scale unchanged.
  - If equal: acc := acc + x.
  - Shift rule: >>> is arithmetic with truncation toward -inf. For d >= acc_width the shifted result is 0 (operand >= 0) or -1 (operand < 0).
  - Saturation: the sum is computed at acc_width+1 bits. Results above 2^(acc_width-1)-1 or below -2^(acc_width-1) saturate to that bound and set ovf.
  - count increments and saturates at max_beats. Accepting beat max_beats+1 sets ovf.
- Single-beat row: a first beat carrying i_last passes through unchanged (sign-extended), with o_count = 1.
- o_dp, o_scale, o_count and o_ovf show the accumulator state while in ACC. They are only meaningful when o_valid = 1.
- Back-to-back rows are allowed. There is no bubble beyond the one-cycle OUT-to-ACC turnaround.

Test Plan:
- Equal scales: beats (10,s5), (20,s5), (-4,s5,last) -> o_valid one cycle after last accept with o_dp = 26, o_scale = 5, o_count = 3, o_ovf = 0.
- Upward alignment: (64,s3), (8,s5,last) -> acc 64>>>2 = 16, plus 8 -> o_dp = 24, o_scale = 5.
- Downward/negative alignment: (16,s4), (-7,s2,last) -> -7>>>2 = -2 -> o_dp = 14, o_scale = 4. Also (5,s0), (-3,s200,last) -> o_dp = -3, o_scale = 200.
- Saturation with acc_width = 10: five beats of (127,s0), last on the 5th -> o_dp = 511, o_ovf = 1. Next row (1,s0,last) -> o_dp = 1, o_ovf = 0.
- Backpressure: hold i_ready = 0 for 5 cycles after o_valid -> o_ready = 0 and outputs stable throughout. Release -> one result handshake, o_ready = 1 the next cycle. A second row streamed immediately after is accumulated independently.
- Reset mid-row: (100,s1), (50,s1), then assert i_rst one cycle -> o_valid = 0, o_ready = 1, o_dp = 0. Then (7,s2,last) -> o_dp = 7, o_scale = 2, o_count = 1.
